req_capture_encoder_4_2: RTL and testbench



---
 rtl/req_enc_pkg.sv | 19 +
 rtl/req_prio_enc_4_2.sv | 28 ++
 rtl/req_capture_encoder_4_2.sv | 87 ++++++++
 tb/tb_req_capture_encoder_4_2.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the request capture / 4-to-2 encoder path.
package req_enc_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/req_prio_enc_4_2.sv
// Combinational 4-to-2 priority encoder with an all-zero flag.
// PRIO_HIGH=1 favours the highest set bit; PRIO_HIGH=0 favours the lowest.
module req_prio_enc_4_2
   import req_enc_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic [N_REQ-1:0] vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             zero_o
);

   // Later loop iterations overwrite earlier ones, so scan order sets the winner.
   always_comb begin
      idx_o  = '0;
      zero_o = (vec_i == '0);
      if (PRIO_HIGH) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
         end
      end else begin
         for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/req_capture_encoder_4_2.sv
// Captures four request lines into a sticky pending set and grants one registered
// index at a time over a valid/ack handshake, with per-line overrun flags.
module req_capture_encoder_4_2
   import req_enc_pkg::*;
#(
   parameter bit EDGE_MODE = 1'b1,
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] d_in,
   input  logic             ack,
   input  logic             clr_overrun,
   output logic [IDX_W-1:0] d_out,
   output logic             valid,
   output logic             invalid_input,
   output logic [N_REQ-1:0] pending,
   output logic [N_REQ-1:0] overrun
);

   logic [N_REQ-1:0] d_q;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] overrun_q, overrun_d;
   logic [N_REQ-1:0] rise_vec, set_vec, clr_vec, ovr_evt;
   logic [IDX_W-1:0] d_out_q, d_out_d;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_zero;
   state_e           state_q, state_d;

   req_prio_enc_4_2 #(
      .PRIO_HIGH(PRIO_HIGH)
   ) u_prio_enc (
      .vec_i (pending_q),
      .idx_o (enc_idx),
      .zero_o(enc_zero)
   );

   // Overruns count only fresh assertions, so a held level never flags in level mode.
   always_comb begin
      rise_vec  = d_in & ~d_q;
      set_vec   = EDGE_MODE ? rise_vec : d_in;
      clr_vec   = (state_q == GRANT && ack) ? onehot_from_idx(d_out_q) : {N_REQ{1'b0}};
      ovr_evt   = rise_vec & pending_q & ~clr_vec;
      pending_d = (pending_q & ~clr_vec) | set_vec;
      overrun_d = (clr_overrun ? {N_REQ{1'b0}} : overrun_q) | ovr_evt;
   end

   always_comb begin
      state_d = state_q;
      d_out_d = d_out_q;
      case (state_q)
         IDLE: begin
            if (!enc_zero) begin
               d_out_d = enc_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q       <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         d_out_q   <= '0;
         state_q   <= IDLE;
      end else begin
         d_q       <= d_in;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         d_out_q   <= d_out_d;
         state_q   <= state_d;
      end
   end

   assign d_out         = d_out_q;
   assign valid         = (state_q == GRANT);
   assign invalid_input = enc_zero;
   assign pending       = pending_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_req_capture_encoder_4_2.sv
// Bench for req_capture_encoder_4_2: three configurations driven in parallel,
// directed scenarios plus a randomized run against a set-based reference model.
module tb_req_capture_encoder_4_2;

   logic       clk;
   logic       rst_n;
   logic [3:0] d_in;
   logic       ack;
   logic       clr_overrun;

   // Instance 0: edge, high prio. 1: edge, low prio. 2: level, high prio.
   logic [1:0] d_out_w [3];
   logic       valid_w [3];
   logic       inv_w   [3];
   logic [3:0] pend_w  [3];
   logic [3:0] ovr_w   [3];

   int n_vec;
   int n_err;

   int         m_gnt  [3];
   logic [3:0] m_pend [3];
   logic [3:0] m_ovr  [3];
   logic [3:0] m_prev;

   req_capture_encoder_4_2 #(.EDGE_MODE(1'b1), .PRIO_HIGH(1'b1)) u_e1p1 (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .ack(ack), .clr_overrun(clr_overrun),
      .d_out(d_out_w[0]), .valid(valid_w[0]), .invalid_input(inv_w[0]),
      .pending(pend_w[0]), .overrun(ovr_w[0]));

   req_capture_encoder_4_2 #(.EDGE_MODE(1'b1), .PRIO_HIGH(1'b0)) u_e1p0 (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .ack(ack), .clr_overrun(clr_overrun),
      .d_out(d_out_w[1]), .valid(valid_w[1]), .invalid_input(inv_w[1]),
      .pending(pend_w[1]), .overrun(ovr_w[1]));

   req_capture_encoder_4_2 #(.EDGE_MODE(1'b0), .PRIO_HIGH(1'b1)) u_e0p1 (
      .clk(clk), .rst_n(rst_n), .d_in(d_in), .ack(ack), .clr_overrun(clr_overrun),
      .d_out(d_out_w[2]), .valid(valid_w[2]), .invalid_input(inv_w[2]),
      .pending(pend_w[2]), .overrun(ovr_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit cfg_edge(input int c);
      return c != 2;
   endfunction

   function automatic bit cfg_hi(input int c);
      return c != 1;
   endfunction

   // Index of the request that wins among the set bits in v.
   function automatic int pick(input logic [3:0] v, input bit hi);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            if (hi) r = i;
            else if (r < 0) r = i;
         end
      end
      return r;
   endfunction

   // {valid, d_out (only meaningful while valid), pending, overrun, invalid_input}
   function automatic logic [11:0] snap(input int c);
      return {valid_w[c], (valid_w[c] ? d_out_w[c] : 2'b00), pend_w[c], ovr_w[c], inv_w[c]};
   endfunction

   function automatic logic [11:0] mk(input logic v, input logic [1:0] d,
                                      input logic [3:0] p, input logic [3:0] o);
      return {v, (v ? d : 2'b00), p, o, (p == 4'b0000)};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         m_gnt[c]  = -1;
         m_pend[c] = 4'b0000;
         m_ovr[c]  = 4'b0000;
      end
      m_prev = 4'b0000;
   endtask

   task automatic model_step(input logic [3:0] din, input logic a, input logic c_ov);
      logic [3:0] newly;
      logic [3:0] old;
      bit         cleared;
      bit         setb;
      newly = din & ~m_prev;
      for (int c = 0; c < 3; c++) begin
         old = m_pend[c];
         if (c_ov) m_ovr[c] = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cleared = (m_gnt[c] == i) && a;
            setb    = cfg_edge(c) ? newly[i] : din[i];
            if (newly[i] && old[i] && !cleared) m_ovr[c][i] = 1'b1;
            m_pend[c][i] = (old[i] && !cleared) || setb;
         end
         if (m_gnt[c] >= 0) begin
            if (a) m_gnt[c] = -1;
         end else if (old != 4'b0000) begin
            m_gnt[c] = pick(old, cfg_hi(c));
         end
      end
      m_prev = din;
   endtask

   task automatic tick(input logic [3:0] din, input logic a, input logic c_ov);
      d_in        = din;
      ack         = a;
      clr_overrun = c_ov;
      @(posedge clk);
      model_step(din, a, c_ov);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      d_in        = 4'b0000;
      ack         = 1'b0;
      clr_overrun = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if (snap(c) !== mk(1'b0, 2'b00, 4'b0000, 4'b0000) || d_out_w[c] !== 2'b00) begin
            n_err++;
            $display("FAIL reset[%0d]: got %b d_out=%b want %b d_out=00", c, snap(c), d_out_w[c],
                     mk(1'b0, 2'b00, 4'b0000, 4'b0000));
         end
      end
   endtask

   task automatic test_single();
      logic [11:0] exp_q [3];
      do_reset();
      exp_q[0] = mk(1'b0, 2'b00, 4'b0010, 4'b0000);
      exp_q[1] = mk(1'b1, 2'b01, 4'b0010, 4'b0000);
      exp_q[2] = mk(1'b0, 2'b00, 4'b0000, 4'b0000);
      for (int s = 0; s < 3; s++) begin
         tick(4'b0010, (s == 2), 1'b0);
         n_vec++;
         if (snap(0) !== exp_q[s]) begin
            n_err++;
            $display("FAIL single step%0d: got %b want %b", s, snap(0), exp_q[s]);
         end
      end
   endtask

   task automatic test_priority();
      logic [1:0] want_d [2][2];
      want_d[0][0] = 2'b11; want_d[0][1] = 2'b01;
      want_d[1][0] = 2'b01; want_d[1][1] = 2'b11;
      do_reset();
      tick(4'b1010, 1'b0, 1'b0);
      for (int g = 0; g < 2; g++) begin
         tick((g == 0) ? 4'b1010 : 4'b0000, 1'b0, 1'b0);
         for (int c = 0; c < 2; c++) begin
            n_vec++;
            if (valid_w[c] !== 1'b1 || d_out_w[c] !== want_d[c][g]) begin
               n_err++;
               $display("FAIL prio[%0d] grant%0d: got v=%b d=%b want v=1 d=%b",
                        c, g, valid_w[c], d_out_w[c], want_d[c][g]);
            end
         end
         tick(4'b0000, 1'b1, 1'b0);
         for (int c = 0; c < 2; c++) begin
            n_vec++;
            if (valid_w[c] !== 1'b0) begin
               n_err++;
               $display("FAIL prio[%0d] bubble%0d: got v=%b want v=0", c, g, valid_w[c]);
            end
         end
      end
      n_vec++;
      if (pend_w[0] !== 4'b0000 || pend_w[1] !== 4'b0000) begin
         n_err++;
         $display("FAIL prio drained: got %b/%b want 0000/0000", pend_w[0], pend_w[1]);
      end
   endtask

   task automatic test_no_preempt();
      do_reset();
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b1001, 1'b0, 1'b0);
      tick(4'b1001, 1'b0, 1'b0);
      n_vec++;
      if (snap(0) !== mk(1'b1, 2'b00, 4'b1001, 4'b0000)) begin
         n_err++;
         $display("FAIL nopreempt hold: got %b want %b", snap(0), mk(1'b1, 2'b00, 4'b1001, 4'b0000));
      end
      tick(4'b1001, 1'b1, 1'b0);
      n_vec++;
      if (snap(0) !== mk(1'b0, 2'b00, 4'b1000, 4'b0000)) begin
         n_err++;
         $display("FAIL nopreempt ack: got %b want %b", snap(0), mk(1'b0, 2'b00, 4'b1000, 4'b0000));
      end
      tick(4'b1001, 1'b0, 1'b0);
      n_vec++;
      if (snap(0) !== mk(1'b1, 2'b11, 4'b1000, 4'b0000)) begin
         n_err++;
         $display("FAIL nopreempt next: got %b want %b", snap(0), mk(1'b1, 2'b11, 4'b1000, 4'b0000));
      end
   endtask

   task automatic test_overrun();
      logic [3:0]  din_q [6];
      logic        ack_q [6];
      logic        clr_q [6];
      logic [11:0] exp_q [6];
      din_q[0] = 4'b0000; ack_q[0] = 0; clr_q[0] = 0; exp_q[0] = mk(1, 2'b10, 4'b0100, 4'b0000);
      din_q[1] = 4'b0100; ack_q[1] = 0; clr_q[1] = 0; exp_q[1] = mk(1, 2'b10, 4'b0100, 4'b0100);
      din_q[2] = 4'b0000; ack_q[2] = 0; clr_q[2] = 1; exp_q[2] = mk(1, 2'b10, 4'b0100, 4'b0000);
      din_q[3] = 4'b0100; ack_q[3] = 1; clr_q[3] = 0; exp_q[3] = mk(0, 2'b00, 4'b0100, 4'b0000);
      din_q[4] = 4'b0000; ack_q[4] = 0; clr_q[4] = 0; exp_q[4] = mk(1, 2'b10, 4'b0100, 4'b0000);
      din_q[5] = 4'b0100; ack_q[5] = 0; clr_q[5] = 1; exp_q[5] = mk(1, 2'b10, 4'b0100, 4'b0100);
      do_reset();
      tick(4'b0100, 1'b0, 1'b0);
      for (int s = 0; s < 6; s++) begin
         tick(din_q[s], ack_q[s], clr_q[s]);
         n_vec++;
         if (snap(0) !== exp_q[s]) begin
            n_err++;
            $display("FAIL overrun step%0d: got %b want %b", s, snap(0), exp_q[s]);
         end
      end
   endtask

   task automatic test_level_ack();
      do_reset();
      for (int s = 0; s < 2; s++) begin
         tick(4'b0000, 1'b1, 1'b0);
         n_vec++;
         if (snap(2) !== mk(1'b0, 2'b00, 4'b0000, 4'b0000) || d_out_w[2] !== 2'b00) begin
            n_err++;
            $display("FAIL idle_ack%0d: got %b want %b", s, snap(2), mk(1'b0, 2'b00, 4'b0000, 4'b0000));
         end
      end
      tick(4'b0001, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
         tick(4'b0001, 1'b0, 1'b0);
         n_vec++;
         if (snap(2) !== mk(1'b1, 2'b00, 4'b0001, 4'b0000)) begin
            n_err++;
            $display("FAIL level grant%0d: got %b want %b", g, snap(2), mk(1'b1, 2'b00, 4'b0001, 4'b0000));
         end
         tick(4'b0001, 1'b1, 1'b0);
         n_vec++;
         if (snap(2) !== mk(1'b0, 2'b00, 4'b0001, 4'b0000)) begin
            n_err++;
            $display("FAIL level ack%0d: got %b want %b", g, snap(2), mk(1'b0, 2'b00, 4'b0001, 4'b0000));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      tick(4'b0100, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      n_vec++;
      if (snap(0) !== mk(1'b1, 2'b10, 4'b0100, 4'b0000)) begin
         n_err++;
         $display("FAIL arst setup: got %b want %b", snap(0), mk(1'b1, 2'b10, 4'b0100, 4'b0000));
      end
      #2 rst_n = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if (snap(c) !== mk(1'b0, 2'b00, 4'b0000, 4'b0000) || d_out_w[c] !== 2'b00) begin
            n_err++;
            $display("FAIL arst[%0d]: got %b d_out=%b want %b d_out=00", c, snap(c), d_out_w[c],
                     mk(1'b0, 2'b00, 4'b0000, 4'b0000));
         end
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [3:0]  din;
      logic [11:0] want;
      do_reset();
      din = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) din = 4'($urandom);
         tick(din, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
         for (int c = 0; c < 3; c++) begin
            want = mk(m_gnt[c] >= 0, 2'(m_gnt[c]), m_pend[c], m_ovr[c]);
            n_vec++;
            if (snap(c) !== want) begin
               n_err++;
               $display("FAIL random[%0d] cyc%0d: got %b want %b", c, n, snap(c), want);
            end
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_priority();
      test_no_preempt();
      test_overrun();
      test_level_ack();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
